// File: rtl/spmv_tile_scheduler.sv
// spmv_tile_scheduler: sequences SpMV tiles (output column > row block > column block) around sparse_accelerator
// Ports: clk/reset_n (async active-low); start/abort job control; cfg_* job dimensions (latched on start, clamped);
//   busy/done status; tile_load strobe with row_blk/col_blk/oa_col tile indices; pe_mac_enable/pe_clear_acc/all_finished
//   accelerator control; oa_wr_valid/oa_wr_ready result-slice handshake; perf_busy_cycles/perf_wait_cycles counters.
// Optional: define SCHED_PERF_CNT_EN to build the saturating perf counters; otherwise they read 0.
module spmv_tile_scheduler #(
    parameter int MAX_ROW_BLKS = 8,
    parameter int MAX_COL_BLKS = 72,
    parameter int MAX_OA_COLS  = 1024,
    parameter int LOAD_LAT     = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [$clog2(MAX_ROW_BLKS+1)-1:0]  cfg_row_blks,
    input  logic [$clog2(MAX_COL_BLKS+1)-1:0]  cfg_col_blks,
    input  logic [$clog2(MAX_OA_COLS+1)-1:0]   cfg_oa_cols,
    output logic                               busy,
    output logic                               done,
    output logic                               tile_load,
    output logic [$clog2(MAX_ROW_BLKS)-1:0]    row_blk,
    output logic [$clog2(MAX_COL_BLKS)-1:0]    col_blk,
    output logic [$clog2(MAX_OA_COLS)-1:0]     oa_col,
    output logic                               pe_mac_enable,
    output logic                               pe_clear_acc,
    input  logic                               all_finished,
    output logic                               oa_wr_valid,
    input  logic                               oa_wr_ready,
    output logic [31:0]                        perf_busy_cycles,
    output logic [31:0]                        perf_wait_cycles
);
    localparam int RW = $clog2(MAX_ROW_BLKS+1);
    localparam int CW = $clog2(MAX_COL_BLKS+1);
    localparam int OW = $clog2(MAX_OA_COLS+1);
    localparam int LW = LOAD_LAT > 1 ? $clog2(LOAD_LAT) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_CLEAR  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;
    logic [2:0]    state;
    logic [LW-1:0] lat_cnt;
    logic [RW-1:0] row_n;
    logic [CW-1:0] col_n;
    logic [OW-1:0] oa_n;
    logic          i_last, j_last, m_last;
    assign i_last = 32'(col_blk) + 32'd1 == 32'(col_n);
    assign j_last = 32'(row_blk) + 32'd1 == 32'(row_n);
    assign m_last = 32'(oa_col) + 32'd1 == 32'(oa_n);
    // Outputs are pure decodes of the state register, so they change only at clock edges.
    assign busy          = state != S_IDLE && state != S_DONE;
    assign done          = state == S_DONE;
    assign tile_load     = state == S_LOAD;
    assign pe_mac_enable = state == S_LOAD || state == S_SETTLE || state == S_WAIT || state == S_DRAIN;
    assign pe_clear_acc  = state == S_IDLE || state == S_CLEAR || state == S_DONE;
    assign oa_wr_valid   = state == S_WRITE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            row_n   <= '0;
            col_n   <= '0;
            oa_n    <= '0;
            row_blk <= '0;
            col_blk <= '0;
            oa_col  <= '0;
        end else if (abort) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            row_blk <= '0;
            col_blk <= '0;
            oa_col  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    row_n   <= cfg_row_blks > RW'(MAX_ROW_BLKS) ? RW'(MAX_ROW_BLKS) : cfg_row_blks;
                    col_n   <= cfg_col_blks > CW'(MAX_COL_BLKS) ? CW'(MAX_COL_BLKS) : cfg_col_blks;
                    oa_n    <= cfg_oa_cols > OW'(MAX_OA_COLS) ? OW'(MAX_OA_COLS) : cfg_oa_cols;
                    row_blk <= '0;
                    col_blk <= '0;
                    oa_col  <= '0;
                    state   <= (cfg_row_blks == '0 || cfg_col_blks == '0 || cfg_oa_cols == '0) ? S_DONE : S_LOAD;
                end
                S_LOAD: begin
                    lat_cnt <= '0;
                    state   <= S_SETTLE;
                end
                S_SETTLE: if (lat_cnt == LW'(LOAD_LAT-1)) state <= S_WAIT;
                          else lat_cnt <= lat_cnt + 1'b1;
                S_WAIT: if (all_finished) begin
                    if (i_last) state <= S_DRAIN;
                    else begin
                        col_blk <= col_blk + 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_DRAIN: if (all_finished) state <= S_WRITE;
                S_WRITE: if (oa_wr_ready) state <= S_CLEAR;
                S_CLEAR: begin
                    col_blk <= '0;
                    if (!j_last) begin
                        row_blk <= row_blk + 1'b1;
                        state   <= S_LOAD;
                    end else begin
                        row_blk <= '0;
                        if (!m_last) begin
                            oa_col <= oa_col + 1'b1;
                            state  <= S_LOAD;
                        end else state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_cycles <= '0;
            perf_wait_cycles <= '0;
        end else if (state == S_IDLE && start && !abort) begin
            perf_busy_cycles <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if ((state == S_WAIT || state == S_DRAIN) && !all_finished && !(&perf_wait_cycles))
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`else
    assign perf_busy_cycles = '0;
    assign perf_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_spmv_tile_scheduler.sv
// tb_spmv_tile_scheduler: scoreboard bench for spmv_tile_scheduler
module tb_spmv_tile_scheduler;
    localparam int LAT = 2;
    logic        clk = 0, reset_n = 0, start = 0, abort = 0, all_finished = 1, oa_wr_ready = 1;
    logic [3:0]  cfg_row_blks = '0;
    logic [6:0]  cfg_col_blks = '0;
    logic [10:0] cfg_oa_cols = '0;
    logic        busy, done, tile_load, pe_mac_enable, pe_clear_acc, oa_wr_valid;
    logic [2:0]  row_blk;
    logic [6:0]  col_blk;
    logic [9:0]  oa_col;
    logic [31:0] perf_busy_cycles, perf_wait_cycles;
    int n_chk = 0, n_err = 0;
    int n_load = 0, n_wr = 0, n_done = 0, n_load_in_wr = 0;
    int vcnt = 0, first_j = 0, first_m = 0, exp_hold = 1, e = 0;
    bit af_stall = 0, rd_stall = 0, exp_clr = 0;
    int q[$];

    spmv_tile_scheduler dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_row_blks(cfg_row_blks), .cfg_col_blks(cfg_col_blks), .cfg_oa_cols(cfg_oa_cols),
        .busy(busy), .done(done), .tile_load(tile_load),
        .row_blk(row_blk), .col_blk(col_blk), .oa_col(oa_col),
        .pe_mac_enable(pe_mac_enable), .pe_clear_acc(pe_clear_acc), .all_finished(all_finished),
        .oa_wr_valid(oa_wr_valid), .oa_wr_ready(oa_wr_ready),
        .perf_busy_cycles(perf_busy_cycles), .perf_wait_cycles(perf_wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Responder: all_finished low for the first 10 WAIT cycles of each tile, ready low for 5 WRITE cycles.
    initial begin
        int since = 100;
        int wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            since = tile_load ? 0 : since + 1;
            wcnt = oa_wr_valid ? wcnt + 1 : 0;
            all_finished = !(af_stall && since >= LAT + 1 && since <= LAT + 10);
            oa_wr_ready = !(rd_stall && wcnt >= 1 && wcnt <= 5);
        end
    end

    always @(negedge clk) if (reset_n) begin
        if (tile_load) begin
            n_load++;
            if (oa_wr_valid) n_load_in_wr++;
        end
        if (done) n_done++;
        if (exp_clr) begin
            chk("clr_after_wr", pe_clear_acc, 1);
            exp_clr = 0;
        end
        if (oa_wr_valid) begin
            vcnt++;
            if (vcnt == 1) begin
                first_j = int'(row_blk);
                first_m = int'(oa_col);
            end
            if (oa_wr_ready) begin
                if (q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("wr_j", row_blk, e / 4096);
                    chk("wr_m", oa_col, e % 4096);
                    chk("wr_j_stable", first_j, e / 4096);
                    chk("wr_m_stable", first_m, e % 4096);
                    chk("wr_hold", vcnt, exp_hold);
                end
                n_wr++;
                vcnt = 0;
                exp_clr = 1;
            end
        end else vcnt = 0;
    end

    task automatic run_job(input int r, input int c, input int o, input int exp_lat, input int exp_wait);
        int rc, cc, oc, n, tiles, slices;
        bit seen;
        rc = r > 8 ? 8 : r;
        cc = c > 72 ? 72 : c;
        oc = o > 1024 ? 1024 : o;
        tiles = rc * cc * oc;
        slices = rc * oc;
        for (int m = 0; m < oc && tiles > 0; m++)
            for (int j = 0; j < rc; j++) q.push_back(j * 4096 + m);
        n_load = 0; n_wr = 0; n_done = 0; n_load_in_wr = 0;
        @(posedge clk);
        #1;
        cfg_row_blks = 4'(r);
        cfg_col_blks = 7'(c);
        cfg_oa_cols = 11'(o);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        n = 0;
        seen = 0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        chk("done_seen", seen, 1);
        chk("latency", n, exp_lat);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_clear", pe_clear_acc, 1);
        chk("tiles", n_load, tiles);
        chk("writes", n_wr, slices * (tiles > 0 ? 1 : 0));
        chk("sb_empty", q.size(), 0);
        chk("dones", n_done, 1);
        chk("load_in_write", n_load_in_wr, 0);
`ifdef SCHED_PERF_CNT_EN
        chk("perf_busy", perf_busy_cycles, n - 1);
        chk("perf_wait", perf_wait_cycles, exp_wait);
`else
        chk("perf_busy", perf_busy_cycles, 0);
        chk("perf_wait", perf_wait_cycles, 0 * exp_wait);
`endif
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", tile_load, 0);
        chk("rst_mac", pe_mac_enable, 0);
        chk("rst_valid", oa_wr_valid, 0);
        chk("rst_clear", pe_clear_acc, 1);
        chk("rst_idx", {row_blk, col_blk, oa_col}, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        // slices*(col_blks*(2+LAT)+3)+1 cycles from the start edge to done with no stalls
        run_job(1, 1, 1, 8, 0);
        run_job(2, 3, 2, 61, 0);
        af_stall = 1;
        run_job(2, 3, 1, 2 * (3 * 14 + 3) + 1, 60);
        af_stall = 0;
        rd_stall = 1;
        exp_hold = 6;
        run_job(1, 1, 2, 25, 0);
        rd_stall = 0;
        exp_hold = 1;
        // start together with abort in IDLE must not launch a job
        @(posedge clk);
        #1;
        cfg_row_blks = 4'd1; cfg_col_blks = 7'd1; cfg_oa_cols = 11'd1;
        start = 1;
        abort = 1;
        @(posedge clk);
        #1;
        start = 0;
        abort = 0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        // abort during SETTLE of the second tile
        n_load = 0; n_done = 0;
        cfg_row_blks = 4'd2; cfg_col_blks = 7'd3; cfg_oa_cols = 11'd2;
        @(posedge clk);
        #1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        n = 0;
        while (n_load < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_tile2", n_load, 2);
        @(posedge clk);
        #1;
        abort = 1;
        @(negedge clk);
        chk("abort_in_settle", pe_mac_enable && !tile_load, 1);
        @(posedge clk);
        #1;
        abort = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_clear", pe_clear_acc, 1);
        chk("abort_mac", pe_mac_enable, 0);
        chk("abort_col", col_blk, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", n_done, 0);
        chk("abort_no_load", n_load, 2);
        run_job(2, 3, 2, 61, 0);
        run_job(1, 0, 1, 1, 0);
        run_job(15, 1, 1, 8 * 7 + 1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
